// File: rtl/train_pkg.sv
// rtl/train_pkg.sv - shared state encoding, data width and training-mode codes for the training sequencer
package train_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_EVAL,
        S_COMMIT,
        S_UPDATE,
        S_WASTE,
        S_CHECK,
        S_REPLAY,
        S_DONE
    } state_t;

    localparam int DEF_BIT_WIDTH  = 32;
    localparam int DEF_EXTRA_BITS = 2;

    function automatic int data_width(input int bit_width, input int extra_bits);
        return bit_width + extra_bits;
    endfunction

    localparam int DEF_DW = data_width(DEF_BIT_WIDTH, DEF_EXTRA_BITS);

    localparam logic MODE_MANHATTAN = 1'b1;
    localparam logic MODE_ADAM      = 1'b0;

endpackage

// File: rtl/burst_counter.sv
// rtl/burst_counter.sv - loadable down-counter that holds at zero and flags terminal count
module burst_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/training_sequencer.sv
// rtl/training_sequencer.sv - training loop sequencer: ROM load, eval, best tracking, update, replay
// TRAIN_SEQ_ADAM_EN enables the Adam phase after the Manhattan iteration limit.
module training_sequencer
    import train_pkg::*;
#(
    parameter int BIT_WIDTH     = DEF_BIT_WIDTH,
    parameter int EXTRA_BITS    = DEF_EXTRA_BITS,
    parameter int NUM_UNKNOWNS  = 2,
    parameter int EXTRA_CYCLES  = 3,
    parameter int EVAL_TIMEOUT  = 64,
    parameter int MAX_ITER_MAN  = 256,
    parameter int MAX_ITER_ADAM = 256,
    parameter int ITER_W        = 16
) (
    input  logic                                         CLK,
    input  logic                                         RESET,
    input  logic                                         START,
    input  logic [data_width(BIT_WIDTH, EXTRA_BITS)-1:0] ERROR_IN,
    input  logic                                         ERROR_VALID,
    input  logic [data_width(BIT_WIDTH, EXTRA_BITS)-1:0] ERROR_THRESHOLD,
    output logic                                         INITIAL_ROM_READ,
    output logic                                         OLD_WEIGHT_RD,
    output logic                                         WRITE_TRAINING,
    output logic                                         BEST_WR_EN,
    output logic                                         STALL,
    output logic                                         FINISHED,
    output logic                                         TRAINING_MODE,
    output logic                                         TRAINING_DONE,
    output logic                                         ERR_TIMEOUT,
    output logic [data_width(BIT_WIDTH, EXTRA_BITS)-1:0] BEST_ERROR,
    output logic [ITER_W-1:0]                            ITER_COUNT
);

    localparam int DW = data_width(BIT_WIDTH, EXTRA_BITS);
    localparam int BW = $clog2(NUM_UNKNOWNS) + 1;
    localparam int XW = $clog2(EXTRA_CYCLES) + 1;
    localparam int TW = $clog2(EVAL_TIMEOUT) + 1;

    state_t            state_q;
    state_t            state_d;
    logic [DW-1:0]     threshold_q;
    logic [DW-1:0]     best_q;
    logic [ITER_W-1:0] iter_q;
    logic [ITER_W-1:0] cur_limit;
    logic              mode_q;
    logic              timeout_q;

    logic run_start;
    logic best_upd;
    logic timeout_set;
    logic iter_inc;
    logic mode_switch;
    logic entering;
    logic burst_tc;
    logic waste_tc;
    logic wdog_tc;

    // mode_q is constant Manhattan when the Adam phase is compiled out
    assign cur_limit = (mode_q == MODE_MANHATTAN) ? ITER_W'(MAX_ITER_MAN) : ITER_W'(MAX_ITER_ADAM);
    assign entering  = (state_d != state_q);

    burst_counter #(.WIDTH(BW)) u_burst (
        .clk        (CLK),
        .resetn     (RESET),
        .load       (entering && (state_d inside {S_LOAD, S_COMMIT, S_UPDATE, S_REPLAY})),
        .load_value (BW'(NUM_UNKNOWNS - 1)),
        .en         (state_q inside {S_LOAD, S_COMMIT, S_UPDATE, S_REPLAY}),
        .tc         (burst_tc)
    );

    burst_counter #(.WIDTH(XW)) u_waste (
        .clk        (CLK),
        .resetn     (RESET),
        .load       (entering && state_d == S_WASTE),
        .load_value (XW'(EXTRA_CYCLES - 1)),
        .en         (state_q == S_WASTE),
        .tc         (waste_tc)
    );

    burst_counter #(.WIDTH(TW)) u_wdog (
        .clk        (CLK),
        .resetn     (RESET),
        .load       (entering && state_d == S_EVAL),
        .load_value (TW'(EVAL_TIMEOUT - 1)),
        .en         (state_q == S_EVAL),
        .tc         (wdog_tc)
    );

    always_comb begin
        state_d     = state_q;
        run_start   = 1'b0;
        best_upd    = 1'b0;
        timeout_set = 1'b0;
        iter_inc    = 1'b0;
        mode_switch = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    run_start = 1'b1;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD:   if (burst_tc) state_d = S_EVAL;
            S_EVAL: begin
                // a valid error in the last watchdog cycle still counts
                if (ERROR_VALID) begin
                    if (ERROR_IN < best_q) begin
                        best_upd = 1'b1;
                        state_d  = S_COMMIT;
                    end else begin
                        state_d = S_UPDATE;
                    end
                end else if (wdog_tc) begin
                    timeout_set = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_COMMIT: if (burst_tc) state_d = S_UPDATE;
            S_UPDATE: if (burst_tc) state_d = S_WASTE;
            S_WASTE: begin
                if (waste_tc) begin
                    iter_inc = 1'b1;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (best_q <= threshold_q) begin
                    state_d = S_REPLAY;
                end else if (iter_q >= cur_limit) begin
`ifdef TRAIN_SEQ_ADAM_EN
                    if (mode_q == MODE_MANHATTAN) begin
                        mode_switch = 1'b1;
                        state_d     = S_EVAL;
                    end else begin
                        state_d = S_REPLAY;
                    end
`else
                    state_d = S_REPLAY;
`endif
                end else begin
                    state_d = S_EVAL;
                end
            end
            S_REPLAY: if (burst_tc) state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q          <= S_IDLE;
            threshold_q      <= '0;
            best_q           <= '1;
            iter_q           <= '0;
            mode_q           <= MODE_MANHATTAN;
            timeout_q        <= 1'b0;
            INITIAL_ROM_READ <= 1'b0;
            OLD_WEIGHT_RD    <= 1'b0;
            WRITE_TRAINING   <= 1'b0;
            BEST_WR_EN       <= 1'b0;
            STALL            <= 1'b0;
            FINISHED         <= 1'b0;
            TRAINING_DONE    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (run_start) begin
                threshold_q <= ERROR_THRESHOLD;
                best_q      <= '1;
                iter_q      <= '0;
                mode_q      <= MODE_MANHATTAN;
                timeout_q   <= 1'b0;
            end else begin
                if (best_upd)    best_q    <= ERROR_IN;
                if (timeout_set) timeout_q <= 1'b1;
                if (mode_switch) begin
                    mode_q <= MODE_ADAM;
                    iter_q <= '0;
                end else if (iter_inc && iter_q != '1) begin
                    iter_q <= iter_q + 1'b1;
                end
            end
            // strobes decode the state being entered so they line up with it
            INITIAL_ROM_READ <= (state_d == S_LOAD);
            OLD_WEIGHT_RD    <= (state_d == S_UPDATE);
            WRITE_TRAINING   <= (state_d == S_UPDATE);
            BEST_WR_EN       <= (state_d == S_COMMIT);
            STALL            <= (state_d == S_EVAL) || (state_d == S_WASTE);
            FINISHED         <= (state_d == S_REPLAY);
            TRAINING_DONE    <= (state_d == S_DONE);
        end
    end

    assign TRAINING_MODE = mode_q;
    assign ERR_TIMEOUT   = timeout_q;
    assign BEST_ERROR    = best_q;
    assign ITER_COUNT    = iter_q;

endmodule

// File: tb/tb_training_sequencer.sv
// tb/tb_training_sequencer.sv - randomized bench for training_sequencer against a segment-level run model
module tb_training_sequencer;

    localparam int DW   = train_pkg::DEF_DW;
    localparam int IW   = 16;
    localparam int N    = 2;
    localparam int E    = 3;
    localparam int TO   = 64;
    localparam int MAN  = 4;
    localparam int ADAM = 3;

    localparam logic [6:0] O_NONE  = 7'b0000000;
    localparam logic [6:0] O_ROM   = 7'b1000000;
    localparam logic [6:0] O_UPD   = 7'b0110000;
    localparam logic [6:0] O_BWR   = 7'b0001000;
    localparam logic [6:0] O_STALL = 7'b0000100;
    localparam logic [6:0] O_FIN   = 7'b0000010;
    localparam logic [6:0] O_DONE  = 7'b0000001;

    localparam int K_START = 0;
    localparam int K_NOISE = 1;
    localparam int K_EVAL  = 2;
    localparam int K_EVALQ = 3;
    localparam int K_QUIET = 4;

    typedef struct {
        logic          start;
        logic          ev;
        logic [DW-1:0] ein;
        logic [8:0]    outv;
        logic [DW-1:0] best;
        logic [IW-1:0] iter;
    } ent_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] error_in;
    logic          error_valid;
    logic [DW-1:0] error_threshold;
    logic          initial_rom_read, old_weight_rd, write_training, best_wr_en;
    logic          stall, finished, training_mode, training_done, err_timeout;
    logic [DW-1:0] best_error;
    logic [IW-1:0] iter_count;
    logic [8:0]    obs;

    int n_checks = 0;
    int n_pass   = 0;

    ent_t          plan[$];
    logic [DW-1:0] err_q[$];
    int            wait_q[$];
    logic [DW-1:0] rnd_lo, rnd_hi;
    bit            rnd_timeouts;
    logic [DW-1:0] m_best;
    logic [IW-1:0] m_iter;
    logic          m_mode, m_to;

    training_sequencer #(
        .NUM_UNKNOWNS  (N),
        .EXTRA_CYCLES  (E),
        .EVAL_TIMEOUT  (TO),
        .MAX_ITER_MAN  (MAN),
        .MAX_ITER_ADAM (ADAM),
        .ITER_W        (IW)
    ) dut (
        .CLK              (clk),
        .RESET            (rst_n),
        .START            (start),
        .ERROR_IN         (error_in),
        .ERROR_VALID      (error_valid),
        .ERROR_THRESHOLD  (error_threshold),
        .INITIAL_ROM_READ (initial_rom_read),
        .OLD_WEIGHT_RD    (old_weight_rd),
        .WRITE_TRAINING   (write_training),
        .BEST_WR_EN       (best_wr_en),
        .STALL            (stall),
        .FINISHED         (finished),
        .TRAINING_MODE    (training_mode),
        .TRAINING_DONE    (training_done),
        .ERR_TIMEOUT      (err_timeout),
        .BEST_ERROR       (best_error),
        .ITER_COUNT       (iter_count)
    );

    assign obs = {initial_rom_read, old_weight_rd, write_training, best_wr_en,
                  stall, finished, training_done, err_timeout, training_mode};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push(input logic [6:0] s, input int cnt, input int kind, input logic [DW-1:0] e);
        for (int i = 0; i < cnt; i++) begin
            ent_t x;
            x.start = (kind == K_START) ? 1'b1 :
                      (kind == K_QUIET) ? 1'b0 : ($urandom_range(0, 7) == 0);
            x.ev    = (kind == K_EVAL)  ? (i == cnt - 1) :
                      (kind == K_NOISE || kind == K_START) ? ($urandom_range(0, 3) == 0) : 1'b0;
            x.ein   = (kind == K_EVAL && x.ev) ? e : DW'($urandom);
            x.outv  = {s, m_to, m_mode};
            x.best  = m_best;
            x.iter  = m_iter;
            plan.push_back(x);
        end
    endtask

    // One run at the granularity of state dwell times; wait 0 means the error never arrives.
    task automatic build_run(input logic [DW-1:0] thr, input bit from_done);
        int            w;
        logic [DW-1:0] e;
        logic [IW-1:0] lim;
        plan.delete();
        if (!from_done) begin
            m_best = '1; m_iter = '0; m_mode = 1'b1; m_to = 1'b0;
        end
        push(from_done ? O_DONE : O_NONE, 1, K_START, '0);
        m_best = '1; m_iter = '0; m_mode = 1'b1; m_to = 1'b0;
        push(O_ROM, N, K_NOISE, '0);
        forever begin
            if (wait_q.size() > 0) w = wait_q.pop_front();
            else if (rnd_timeouts && $urandom_range(0, 19) == 0) w = 0;
            else w = $urandom_range(1, 8);
            if (w == 0) begin
                push(O_STALL, TO, K_EVALQ, '0);
                m_to = 1'b1;
                break;
            end
            if (err_q.size() > 0) e = err_q.pop_front();
            else e = rnd_lo + DW'($urandom_range(0, 32'(rnd_hi - rnd_lo)));
            push(O_STALL, w, K_EVAL, e);
            if (e < m_best) begin
                m_best = e;
                push(O_BWR, N, K_NOISE, '0);
            end
            push(O_UPD, N, K_NOISE, '0);
            push(O_STALL, E, K_NOISE, '0);
            if (m_iter != '1) m_iter = m_iter + 1'b1;
            push(O_NONE, 1, K_NOISE, '0);
            if (m_best <= thr) break;
            lim = m_mode ? IW'(MAN) : IW'(ADAM);
            if (m_iter >= lim) begin
`ifdef TRAIN_SEQ_ADAM_EN
                if (m_mode) begin
                    m_mode = 1'b0;
                    m_iter = '0;
                    continue;
                end
`endif
                break;
            end
        end
        if (!m_to) push(O_FIN, N, K_NOISE, '0);
        push(O_DONE, 4, K_QUIET, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; error_valid = 1'b0; error_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_plan(input logic [DW-1:0] thr, input int rst_at);
        error_threshold = thr;
        for (int t = 0; t < plan.size(); t++) begin
            @(negedge clk);
            check_eq($sformatf("strobes@%0d", t), 64'(obs), 64'(plan[t].outv));
            check_eq($sformatf("best_error@%0d", t), 64'(best_error), 64'(plan[t].best));
            check_eq($sformatf("iter_count@%0d", t), 64'(iter_count), 64'(plan[t].iter));
            if (t == rst_at) begin
                rst_n = 1'b0; start = 1'b0; error_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                check_eq("reset_strobes", 64'(obs), 64'({7'b0, 1'b0, 1'b1}));
                check_eq("reset_best", 64'(best_error), 64'({DW{1'b1}}));
                check_eq("reset_iter", 64'(iter_count), 64'd0);
                return;
            end
            start       = plan[t].start;
            error_valid = plan[t].ev;
            error_in    = plan[t].ein;
        end
    endtask

    task automatic scenario(input logic [DW-1:0] thr, input bit from_done, input bit rst_last_upd);
        int rst_at;
        build_run(thr, from_done);
        rst_at = -1;
        if (rst_last_upd) begin
            for (int i = 0; i < plan.size(); i++)
                if (plan[i].outv[8:2] == O_UPD) rst_at = i;
        end
        run_plan(thr, rst_at);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; error_valid = 1'b0; error_in = '0; error_threshold = '0;
        rnd_timeouts = 1'b0;
        do_reset();
        @(negedge clk);
        check_eq("reset_state", 64'(obs), 64'({7'b0, 1'b0, 1'b1}));
        check_eq("reset_best_error", 64'(best_error), 64'({DW{1'b1}}));

        // first error 5 cycles after START, then 100/120/80 improvement pattern
        wait_q = '{3}; err_q = '{100, 120, 80};
        rnd_lo = 90; rnd_hi = 1000;
        do_reset(); scenario(0, 1'b0, 1'b0);

        wait_q = '{}; err_q = '{60, 40};
        do_reset(); scenario(50, 1'b0, 1'b0);

        rnd_lo = 200; rnd_hi = 200;
        do_reset(); scenario(0, 1'b0, 1'b0);
        do_reset(); scenario(0, 1'b0, 1'b1);

        wait_q = '{0};
        do_reset(); scenario(0, 1'b0, 1'b0);

        wait_q = '{TO, 1}; err_q = '{500};
        rnd_lo = 0; rnd_hi = 1000;
        do_reset(); scenario(0, 1'b0, 1'b0);

        err_q = '{34'h3_0000_0000, 34'h2_ffff_ffff, 34'h1_0000_0000, 34'h3_ffff_ffff};
        rnd_lo = 34'h1_0000_0001; rnd_hi = 34'h1_0000_ffff;
        do_reset(); scenario(34'h0_ffff_ffff, 1'b0, 1'b0);

        // random runs chained through DONE so restart-from-DONE is exercised
        rnd_timeouts = 1'b1;
        do_reset();
        for (int r = 0; r < 10; r++) begin
            rnd_lo = DW'($urandom_range(0, 100));
            rnd_hi = rnd_lo + DW'($urandom_range(0, 900));
            scenario(DW'($urandom_range(0, 300)), r != 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/training_sequencer.md
# training_sequencer

Sequencing controller for the Newton-style training loop. It drives the initial-guess ROM read, lets the forward/backward engines settle, captures the squared error and tracks the best one. It then steps the training block through weight write-back and update-stall cycles, switches Manhattan→Adam, and finally replays the best-weight buffer. It replaces the hard-wired control unit between the engines, the two weight FIFOs and the training block.

## Interface
- BIT_WIDTH, 32, weight/error mantissa width
- EXTRA_BITS, 2, guard bits; data width DW = BIT_WIDTH+EXTRA_BITS
- NUM_UNKNOWNS, 2, weights per vector (cycles per load/write/replay burst)
- EXTRA_CYCLES, 3, stall cycles consumed by a weight update
- EVAL_TIMEOUT, 64, max cycles waiting for ERROR_VALID
- MAX_ITER_MAN, 256, Manhattan iterations
- MAX_ITER_ADAM, 256, Adam iterations
- ITER_W, 16, iteration counter width
- CLK  in  1  clock, all logic on rising edge
- RESET  in  1  synchronous, active-low reset
- START  in  1  one-cycle pulse, begins a run from IDLE
- ERROR_IN  in  DW  unsigned squared error from backward engine
- ERROR_VALID  in  1  ERROR_IN valid this cycle
- ERROR_THRESHOLD  in  DW  convergence target, sampled at START
- INITIAL_ROM_READ  out  1  select ROM as engine input; write old-weight FIFO
- OLD_WEIGHT_RD  out  1  pop old-weight FIFO
- WRITE_TRAINING  out  1  push training-block result into old-weight FIFO
- BEST_WR_EN  out  1  push current weight into best-weight FIFO
- STALL  out  1  freeze training block and FIFOs
- FINISHED  out  1  best-weight replay active
- TRAINING_MODE  out  1  1 = Manhattan, 0 = Adam
- TRAINING_DONE  out  1  level, run complete (converged or iterations exhausted)
- ERR_TIMEOUT  out  1  sticky, eval watchdog fired
- BEST_ERROR  out  DW  lowest error seen this run
- ITER_COUNT  out  ITER_W  iterations completed in current mode

## Operation
- States: IDLE, LOAD, EVAL, COMMIT, UPDATE, WASTE, CHECK, REPLAY, DONE.
- IDLE: all strobes 0. START latches the threshold, clears counters, sets BEST_ERROR to all-ones and goes to LOAD.
- LOAD: INITIAL_ROM_READ=1 for NUM_UNKNOWNS cycles, then EVAL.
- EVAL: STALL=1 and the watchdog counts.
  - ERROR_VALID with ERROR_IN < BEST_ERROR (unsigned): update BEST_ERROR, go COMMIT.
  - ERROR_VALID otherwise: go UPDATE.
  - Watchdog reaching EVAL_TIMEOUT with no ERROR_VALID: set ERR_TIMEOUT and go DONE.
- COMMIT: BEST_WR_EN=1 for NUM_UNKNOWNS cycles, then UPDATE.
- UPDATE: OLD_WEIGHT_RD=1 and WRITE_TRAINING=1 together for NUM_UNKNOWNS cycles, then WASTE.
- WASTE: STALL=1 for EXTRA_CYCLES cycles, then CHECK. ITER_COUNT increments on exit.
- CHECK takes one cycle and evaluates in priority order:
  - BEST_ERROR ≤ threshold → REPLAY.
  - Iteration limit of current mode reached while in Manhattan → TRAINING_MODE=0, clear ITER_COUNT, go EVAL.
  - Iteration limit reached while in Adam → REPLAY.
  - Otherwise → EVAL.
- REPLAY: FINISHED=1 for NUM_UNKNOWNS cycles, then DONE.
- DONE: TRAINING_DONE=1. Hold until START, which restarts from LOAD.
- ERROR_VALID outside EVAL is ignored. START outside IDLE/DONE is ignored.

## Timing
- Reset value of every output is 0, except BEST_ERROR = all-ones and TRAINING_MODE = 1.
- All outputs are registered and decoded from state and counters; each is valid the cycle after the state is entered.
- START→first INITIAL_ROM_READ: 1 cycle.
- One non-improving iteration: EVAL wait + NUM_UNKNOWNS + EXTRA_CYCLES + 1 cycles.
- An improving iteration adds NUM_UNKNOWNS cycles for COMMIT.
- ERROR_VALID on the same cycle the watchdog expires: the error wins and no timeout is flagged.
- Reset asserted mid-run: IDLE next cycle and all strobes drop immediately, whatever the state. FIFOs are reset by the same RESET.
- ITER_COUNT saturates at its maximum; it never wraps.

## Configuration
- TRAIN_SEQ_ADAM_EN defined: Manhattan phase is followed by the Adam phase as described above.
- TRAIN_SEQ_ADAM_EN undefined: TRAINING_MODE is held at 1. Reaching MAX_ITER_MAN goes straight to REPLAY, and MAX_ITER_ADAM is unused.

## Structure
- Shared package `train_pkg` holds:
  - the state enum;
  - DW as a localparam function of BIT_WIDTH and EXTRA_BITS;
  - the mode encodings MODE_MANHATTAN=1 and MODE_ADAM=0.
- One sub-module, `burst_counter`: a loadable down-counter with a terminal flag. It is instantiated for the NUM_UNKNOWNS bursts, EXTRA_CYCLES and the watchdog.

## Test plan
- Reset mid-UPDATE with RESET=0 for 1 cycle → next cycle IDLE, all strobes 0, BEST_ERROR=all-ones, TRAINING_MODE=1.
- NUM_UNKNOWNS=2, EXTRA_CYCLES=3, START, ERROR_VALID 5 cycles later with ERROR_IN=100 → ROM read 2 cycles, COMMIT 2, UPDATE 2, WASTE 3, BEST_ERROR=100, ITER_COUNT=1.
- Errors 100, 120, 80 → BEST_WR_EN bursts on iterations 1 and 3 only; BEST_ERROR=80.
- Threshold 50, error 40 on iteration 2 → CHECK→REPLAY, FINISHED for 2 cycles, TRAINING_DONE=1, ITER_COUNT=2.
- MAX_ITER_MAN=4, MAX_ITER_ADAM=3, errors always 200, threshold 0 → TRAINING_MODE falls after 4 iterations, DONE after 3 more. Without TRAIN_SEQ_ADAM_EN → DONE after 4, TRAINING_MODE stays 1.
- No ERROR_VALID for EVAL_TIMEOUT=64 cycles → ERR_TIMEOUT=1, DONE, no FINISHED. ERROR_VALID on cycle 64 → no timeout flagged.
